decode_queue: RTL and testbench

- Buffered, parametrised instruction decoder between fetch and dispatch.
- Accepts raw 32-bit RV32I instructions with their PC into a DEPTH-entry FIFO.
- Decodes the FIFO head into op/rd/rs1/rs2/imm and presents it on a valid/ready output port.
- Flushes on branch mispredict; also decodes unknown encodings deterministically.

---
 rtl/decode_queue_pkg.sv | 43 ++++
 rtl/decode_queue_inst_decode_unit.sv | 174 +++++++++++++++++
 rtl/decode_queue.sv | 119 +++++++++++
 tb/tb_decode_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared opcode constants, internal op codes, decode formats
// and the FIFO entry payload used by decode_queue and inst_decode_unit.
package decode_queue_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OP_ENC_W = 6;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [OP_ENC_W-1:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/decode_queue_inst_decode_unit.sv
// inst_decode_unit: purely combinational RV32I decode of one instruction word.
// Ports: i_inst (raw word) -> o_op_c, o_rd_c, o_rs1_c, o_rs2_c, o_imm_c, o_is_ls_c
// and, with DECODE_QUEUE_ILLEGAL_EN defined, o_illegal_c.
// Unused register fields read as NULL ({1'b1, zeros}); unused immediates read 0.
module inst_decode_unit
    import decode_queue_pkg::*;
#(
    parameter int unsigned REG_W = 6,
    parameter int unsigned OP_W  = 6
) (
    input  logic [31:0]      i_inst,
    output logic [OP_W-1:0]  o_op_c,
    output logic [REG_W-1:0] o_rd_c,
    output logic [REG_W-1:0] o_rs1_c,
    output logic [REG_W-1:0] o_rs2_c,
    output logic [31:0]      o_imm_c,
`ifdef DECODE_QUEUE_ILLEGAL_EN
    output logic             o_illegal_c,
`endif
    output logic             o_is_ls_c
);

    localparam logic [REG_W-1:0] NULL_REG = {1'b1, {(REG_W-1){1'b0}}};

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    op_e        w_op;
    fmt_e       w_fmt;
    logic       w_ls;
    logic       w_bad_core;
    logic       w_kill;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_f7  = i_inst[31:25];

    // Opcode / func3 / func7 -> op, operand format; w_bad_core marks encodings always forced to NOP
    always_comb begin
        w_op       = OP_NOP;
        w_fmt      = FMT_NONE;
        w_ls       = 1'b0;
        w_bad_core = 1'b0;
        case (w_opc)
            OPC_LUI:   begin w_op = OP_LUI;   w_fmt = FMT_U; end
            OPC_AUIPC: begin w_op = OP_AUIPC; w_fmt = FMT_U; end
            OPC_JAL:   begin w_op = OP_JAL;   w_fmt = FMT_J; end
            OPC_JALR:  begin w_op = OP_JALR;  w_fmt = FMT_I; end
            OPC_B: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_bad_core = 1'b1;
                endcase
            end
            OPC_L: begin
                w_fmt = FMT_I;
                w_ls  = 1'b1;
                case (w_f3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_bad_core = 1'b1;
                endcase
            end
            OPC_S: begin
                w_fmt = FMT_S;
                w_ls  = 1'b1;
                case (w_f3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_bad_core = 1'b1;
                endcase
            end
            OPC_I: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b001: w_op = OP_SLLI;
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b101: w_op = i_inst[30] ? OP_SRAI : OP_SRLI;
                    3'b110: w_op = OP_ORI;
                    default: w_op = OP_ANDI;
                endcase
            end
            OPC_R: begin
                w_fmt = FMT_R;
                case (w_f3)
                    3'b000: w_op = (w_f7 == F7_ALT) ? OP_SUB : OP_ADD;
                    3'b001: w_op = OP_SLL;
                    3'b010: w_op = OP_SLT;
                    3'b011: w_op = OP_SLTU;
                    3'b100: w_op = OP_XOR;
                    3'b101: w_op = (w_f7 == F7_ALT) ? OP_SRA : OP_SRL;
                    3'b110: w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
            default: w_bad_core = 1'b1;
        endcase
    end

`ifdef DECODE_QUEUE_ILLEGAL_EN
    logic w_bad_ext;
    // Encodings that decode silently in the base build but are flagged here
    assign w_bad_ext = ((w_opc == OPC_R || (w_opc == OPC_I && w_f3 == 3'b101))
                        && !(w_f7 == F7_BASE || w_f7 == F7_ALT))
                     || (w_opc == OPC_I && w_f3 == 3'b001 && w_f7 != F7_BASE)
                     || (w_opc == OPC_JALR && w_f3 != 3'b000);
    assign w_kill      = w_bad_core | w_bad_ext;
    assign o_illegal_c = w_kill;
`else
    assign w_kill = w_bad_core;
`endif

    // Format-driven field selection; killed encodings collapse to a clean NOP
    always_comb begin
        o_op_c    = OP_W'(w_op);
        o_rd_c    = REG_W'(i_inst[11:7]);
        o_rs1_c   = REG_W'(i_inst[19:15]);
        o_rs2_c   = REG_W'(i_inst[24:20]);
        o_imm_c   = 32'd0;
        o_is_ls_c = w_ls;
        case (w_fmt)
            FMT_R: ;
            FMT_I: begin
                o_rs2_c = NULL_REG;
                o_imm_c = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            FMT_S: begin
                o_rd_c  = NULL_REG;
                o_imm_c = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            FMT_B: begin
                o_rd_c  = NULL_REG;
                o_imm_c = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            end
            FMT_U: begin
                o_rs1_c = NULL_REG;
                o_rs2_c = NULL_REG;
                o_imm_c = {i_inst[31:12], 12'b0};
            end
            FMT_J: begin
                o_rs1_c = NULL_REG;
                o_rs2_c = NULL_REG;
                o_imm_c = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            end
            default: begin
                o_rd_c  = NULL_REG;
                o_rs1_c = NULL_REG;
                o_rs2_c = NULL_REG;
            end
        endcase
        if (w_kill) begin
            o_op_c    = OP_W'(OP_NOP);
            o_rd_c    = NULL_REG;
            o_rs1_c   = NULL_REG;
            o_rs2_c   = NULL_REG;
            o_imm_c   = 32'd0;
            o_is_ls_c = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO between fetch and dispatch with
// the head decoded combinationally by inst_decode_unit.
// Ports: clk_in, rst_in (async, active-low), rdy_in (global pause), flush_in;
//   in_valid/in_ready/in_inst/in_pc (push side);
//   out_valid/out_ready/out_pc/out_op/out_rd/out_rs1/out_rs2/out_imm/out_is_ls (pop side);
//   count_out (occupancy). Macro DECODE_QUEUE_ILLEGAL_EN adds out_illegal.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned REG_W = 6,
    parameter int unsigned OP_W  = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [OP_W-1:0]        out_op,
    output logic [REG_W-1:0]       out_rd,
    output logic [REG_W-1:0]       out_rs1,
    output logic [REG_W-1:0]       out_rs2,
    output logic [31:0]            out_imm,
    output logic                   out_is_ls,
`ifdef DECODE_QUEUE_ILLEGAL_EN
    output logic                   out_illegal,
`endif
    output logic [$clog2(DEPTH):0] count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    fifo_entry_t w_head;
    fifo_entry_t w_wr_entry;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = rdy_in & ~w_full;
    assign out_valid = rdy_in & ~w_empty;
    // in_ready/out_valid already carry rdy_in; flush overrides both transfers
    assign w_push    = in_valid & in_ready & ~flush_in;
    assign w_pop     = out_valid & out_ready & ~flush_in;
    assign count_out = r_count;

    assign w_wr_entry = '{inst: in_inst, pc: in_pc};
    // Empty queue presents a zero word so the decode is a deterministic NOP
    assign w_head = w_empty ? '0 : r_mem[r_head];

    // Pointer and occupancy control
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_pop)  r_head <= r_head + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Payload storage; contents are don't-care outside [head, tail)
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_tail] <= w_wr_entry;
    end

`ifdef DECODE_QUEUE_ILLEGAL_EN
    logic w_illegal;
`endif

    inst_decode_unit #(
        .REG_W (REG_W),
        .OP_W  (OP_W)
    ) u_dec (
        .i_inst      (w_head.inst),
        .o_op_c      (out_op),
        .o_rd_c      (out_rd),
        .o_rs1_c     (out_rs1),
        .o_rs2_c     (out_rs2),
        .o_imm_c     (out_imm),
`ifdef DECODE_QUEUE_ILLEGAL_EN
        .o_illegal_c (w_illegal),
`endif
        .o_is_ls_c   (out_is_ls)
    );

    assign out_pc = w_head.pc;

`ifdef DECODE_QUEUE_ILLEGAL_EN
    assign out_illegal = out_valid & w_illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: self-checking bench for decode_queue (DEPTH=4) using an
// expected-decode scoreboard pushed on stimulus and popped at each dequeue.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned REG_W = 6;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 3;
    localparam logic [REG_W-1:0] NR = 6'd32;

    typedef struct packed {
        logic [31:0]      pc;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [31:0]      imm;
        logic             is_ls;
    } dec_t;

    logic             clk_in, rst_in, rdy_in, flush_in;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_inst, in_pc, out_pc, out_imm;
    logic [OP_W-1:0]  out_op;
    logic [REG_W-1:0] out_rd, out_rs1, out_rs2;
    logic             out_is_ls;
    logic [CNT_W-1:0] count_out;
`ifdef DECODE_QUEUE_ILLEGAL_EN
    logic             out_illegal;
`endif

    dec_t obs;
    dec_t exp_d;
    dec_t exp_q[$];
    int   n_checks;
    int   n_fail;

    decode_queue #(.DEPTH(DEPTH), .REG_W(REG_W), .OP_W(OP_W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_imm   (out_imm),
        .out_is_ls (out_is_ls),
`ifdef DECODE_QUEUE_ILLEGAL_EN
        .out_illegal (out_illegal),
`endif
        .count_out (count_out)
    );

    always_comb obs = {out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm, out_is_ls};

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic dec_t mk(input logic [31:0] pc, input op_e op, input logic [REG_W-1:0] rd,
                                input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                input logic [31:0] imm, input logic ls);
        mk = '{pc: pc, op: OP_W'(op), rd: rd, rs1: rs1, rs2: rs2, imm: imm, is_ls: ls};
    endfunction

    function automatic logic [31:0] addi_inst(input logic [4:0] rd, input logic [11:0] imm);
        addi_inst = {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic dec_t addi_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [11:0] imm);
        addi_exp = mk(pc, OP_ADDI, REG_W'(rd), 6'd0, NR, {{20{imm[11]}}, imm}, 1'b0);
    endfunction

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;
        repeat (2) @(negedge clk_in);
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        exp_d = mk(32'd0, OP_NOP, NR, NR, NR, 32'd0, 1'b0);
        n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL reset_decode: got %h want %h", obs, exp_d); end
        rst_in = 1'b1;
        @(negedge clk_in);
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL reset_release_count: got %0d want 0", count_out); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0;
        exp_q.push_back(mk(32'h0, OP_ADDI, 6'd1, 6'd0, NR, 32'd5, 1'b0));
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_bypass: got %b want 0", out_valid); end
        @(negedge clk_in);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_out_valid: got %b want 1", out_valid); end
        n_checks++; if (count_out !== 3'd1) begin n_fail++; $display("FAIL addi_count: got %0d want 1", count_out); end
        exp_d = exp_q.pop_front();
        n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL addi_decode: got %h want %h", obs, exp_d); end
        out_ready = 1'b1;
        @(negedge clk_in);
        out_ready = 1'b0;
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL addi_pop_count: got %0d want 0", count_out); end
    endtask

    task automatic test_sw_beq();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0020A423; in_pc = 32'h4;
        exp_q.push_back(mk(32'h4, OP_SW, NR, 6'd1, 6'd2, 32'd8, 1'b1));
        @(negedge clk_in);
        in_inst = 32'hFE000EE3; in_pc = 32'h8;
        exp_q.push_back(mk(32'h8, OP_BEQ, NR, 6'd0, 6'd0, 32'hFFFFFFFC, 1'b0));
        @(negedge clk_in);
        in_valid = 1'b0;
        n_checks++; if (count_out !== 3'd2) begin n_fail++; $display("FAIL swbeq_count: got %0d want 2", count_out); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_d = exp_q.pop_front();
            n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL swbeq_decode%0d: got %h want %h", i, obs, exp_d); end
            @(negedge clk_in);
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL swbeq_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_decode_mix();
        logic [31:0] insts [5];
        dec_t        exps  [5];
        insts[0] = 32'h402081B3; exps[0] = mk(32'h200, OP_SUB, 6'd3, 6'd1, 6'd2, 32'd0, 1'b0);
        insts[1] = 32'h022081B3; exps[1] = mk(32'h204, OP_ADD, 6'd3, 6'd1, 6'd2, 32'd0, 1'b0);
        insts[2] = 32'hFFC12283; exps[2] = mk(32'h208, OP_LW,  6'd5, 6'd2, NR, 32'hFFFFFFFC, 1'b1);
        insts[3] = 32'hFFC13283; exps[3] = mk(32'h20C, OP_NOP, NR, NR, NR, 32'd0, 1'b0);
        insts[4] = 32'hFFFFFFFF; exps[4] = mk(32'h210, OP_NOP, NR, NR, NR, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h200 + 32'(4 * i);
            exp_q.push_back(exps[i]);
            @(negedge clk_in);
            in_valid = 1'b0; out_ready = 1'b1;
            exp_d = exp_q.pop_front();
            n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL mix_decode%0d: got %h want %h", i, obs, exp_d); end
            @(negedge clk_in);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = addi_inst(5'(i + 1), 12'(i * 3)); in_pc = 32'h100 + 32'(4 * i);
            #1;
            n_checks++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL full_in_ready%0d: got %b want %b", i, in_ready, (i < 4)); end
            if (i < 4) exp_q.push_back(addi_exp(32'h100 + 32'(4 * i), 5'(i + 1), 12'(i * 3)));
            @(negedge clk_in);
        end
        in_valid = 1'b0;
        n_checks++; if (count_out !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count_out); end
        // Full queue with a concurrent pop must still refuse the push
        in_valid = 1'b1; in_inst = addi_inst(5'd31, 12'hABC); in_pc = 32'hDEAD0000; out_ready = 1'b1;
        exp_d = exp_q.pop_front();
        n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL full_head0: got %h want %h", obs, exp_d); end
        @(negedge clk_in);
        in_valid = 1'b0;
        n_checks++; if (count_out !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want 3", count_out); end
        for (int i = 1; i < 4; i++) begin
            exp_d = exp_q.pop_front();
            n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL full_head%0d: got %h want %h", i, obs, exp_d); end
            @(negedge clk_in);
        end
        out_ready = 1'b0;
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL full_drain_count: got %0d want 0", count_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = addi_inst(5'(i + 10), 12'(100 + i)); in_pc = 32'h300 + 32'(4 * i);
            exp_q.push_back(addi_exp(32'h300 + 32'(4 * i), 5'(i + 10), 12'(100 + i)));
            @(negedge clk_in);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (count_out !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d: got %0d want 2", c, count_out); end
            exp_d = exp_q.pop_front();
            n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL b2b_head%0d: got %h want %h", c, obs, exp_d); end
            in_inst = addi_inst(5'(c + 2), 12'h800 + 12'(c)); in_pc = 32'h400 + 32'(4 * c);
            exp_q.push_back(addi_exp(32'h400 + 32'(4 * c), 5'(c + 2), 12'h800 + 12'(c)));
            @(negedge clk_in);
        end
        in_valid = 1'b0;
        n_checks++; if (count_out !== 3'd2) begin n_fail++; $display("FAIL b2b_final_count: got %0d want 2", count_out); end
        for (int i = 0; i < 2; i++) begin
            exp_d = exp_q.pop_front();
            n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL b2b_drain%0d: got %h want %h", i, obs, exp_d); end
            @(negedge clk_in);
        end
        out_ready = 1'b0;
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d want 0", count_out); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = addi_inst(5'(i + 20), 12'(i)); in_pc = 32'h500 + 32'(4 * i);
            exp_q.push_back(addi_exp(32'h500 + 32'(4 * i), 5'(i + 20), 12'(i)));
            @(negedge clk_in);
        end
        in_valid = 1'b0;
        n_checks++; if (count_out !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count_out); end
        // Paused: flush, push and pop must all be ignored
        rdy_in = 1'b0; flush_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pause_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pause_out_valid: got %b want 0", out_valid); end
        @(negedge clk_in);
        rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (count_out !== 3'd3) begin n_fail++; $display("FAIL pause_count: got %0d want 3", count_out); end
        exp_d = exp_q[0];
        n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL pause_head: got %h want %h", obs, exp_d); end
        @(negedge clk_in);
        flush_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_inst = addi_inst(5'd9, 12'd9);
        @(negedge clk_in);
        flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        in_valid = 1'b1; in_inst = addi_inst(5'd7, 12'h7FF); in_pc = 32'h600;
        exp_q.push_back(addi_exp(32'h600, 5'd7, 12'h7FF));
        @(negedge clk_in);
        in_valid = 1'b0; out_ready = 1'b1;
        exp_d = exp_q.pop_front();
        n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL post_flush_head: got %h want %h", obs, exp_d); end
        @(negedge clk_in);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = addi_inst(5'(i + 1), 12'(i)); in_pc = 32'h700 + 32'(4 * i);
            @(negedge clk_in);
        end
        n_checks++; if (count_out !== 3'd3) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 3", count_out); end
        #2 rst_in = 1'b0;
        #1;
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", count_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        exp_d = mk(32'd0, OP_NOP, NR, NR, NR, 32'd0, 1'b0);
        n_checks++; if (obs !== exp_d) begin n_fail++; $display("FAIL midrst_decode: got %h want %h", obs, exp_d); end
        @(negedge clk_in);
        in_valid = 1'b0; rst_in = 1'b1;
        @(negedge clk_in);
        n_checks++; if (count_out !== 3'd0) begin n_fail++; $display("FAIL midrst_after_count: got %0d want 0", count_out); end
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_addi();
        test_sw_beq();
        test_decode_mix();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
